pixel_fb_writer: RTL and testbench
==================================

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter FB_ADDR_W, default 16, framebuffer word-address width.
REQ-002 SHALL have parameter COLOR_W, default 8, pixel color width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports pixel_color/pixel_x/pixel_y  input  COLOR_W/11/11  rasterizer pixel stream.
REQ-006 SHALL have ports pixel_valid  input  1  and  pixel_ready  output  1  as the stream handshake.
REQ-007 SHALL have port draw  input  1  pixel coverage flag, qualified by pixel_valid.
REQ-008 SHALL have ports width/height  input  11/11  active frame size in pixels.
REQ-009 SHALL have port frame_end  input  1  level from the rasterizer; high = frame finished.
REQ-010 SHALL have ports clear_start  input  1  and  clear_color  input  COLOR_W  to request a framebuffer fill.
REQ-011 SHALL have ports fb_wr_en/fb_wr_addr/fb_wr_data  output  1/FB_ADDR_W/COLOR_W  framebuffer write port; no backpressure.
REQ-012 SHALL have ports busy  output  1,  frame_done  output  1 (pulse),  pixel_count  output  32,  drop_count  output  16.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, FLUSH, DONE.
REQ-014 pixel_ready SHALL be 1 only in IDLE with clear_start low; a pixel transfers when pixel_valid and pixel_ready are both 1.
REQ-015 SHALL compute addr = pixel_y*width + pixel_x at full 23-bit precision, then truncate to FB_ADDR_W (modulo wrap).
REQ-016 A transferred pixel with draw=1, pixel_x<width and pixel_y<height SHALL produce exactly one write: fb_wr_en=1 exactly 2 cycles after transfer, with the computed address and pixel_color.
REQ-017 A transferred pixel with draw=0 SHALL be discarded silently; one failing the bounds check SHALL be discarded and increment drop_count, saturating at 16'hFFFF.
REQ-018 The pipeline SHALL sustain one transfer per cycle; each write increments pixel_count (wraps at 2^32).
REQ-019 IDLE with clear_start=1 SHALL go to CLEAR, latching clear_color and limit=width*height, zeroing pixel_count and drop_count; any pixel offered that cycle is not accepted.
REQ-020 CLEAR SHALL write clear_color to addresses 0..limit-1, one per cycle, in order, then return to IDLE; limit=0 SHALL give zero writes and return to IDLE next cycle.
REQ-021 IDLE with a rising edge of frame_end (0 last cycle, 1 now) SHALL go to FLUSH; that cycle's pixel is still accepted.
REQ-022 FLUSH SHALL wait until both pipeline stages are empty, then go to DONE; DONE SHALL assert frame_done for exactly 1 cycle and return to IDLE.
REQ-023 clear_start SHALL be ignored outside IDLE; frame_end edges SHALL be ignored outside IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE and while any pipeline stage holds a pixel.
REQ-025 Clear writes and pixel writes SHALL never collide; CLEAR is entered only with the pipeline empty (wait in IDLE, pixel_ready low, until drained).

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, pipeline empty, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0, busy=0, pixel_count=0, drop_count=0, edge-detect register=1.
REQ-027 Reset asserted mid-CLEAR or mid-pipeline SHALL abandon the operation with no further writes; deassertion is synchronized externally.

Structure
REQ-028 The FSM state typedef, pixel coordinate width (11) and COLOR_W default SHALL live in shared package gpu_pkg.
REQ-029 The address multiply/bounds check SHALL be a sub-module fb_addr_calc (registered, 1 cycle latency).

Verification
REQ-030 width=4, height=3, pixel (x=2,y=1,color=8'h5A,draw=1) -> fb_wr_en 2 cycles later, addr 6, data 8'h5A, pixel_count=1.
REQ-031 Back-to-back 12 pixels, full 4x3 frame, valid held high -> 12 consecutive writes, addresses 0..11, no ready deassertion.
REQ-032 Pixels (x=4,y=0) and (x=0,y=3) with width=4, height=3 -> no writes, drop_count=2; draw=0 pixel -> no write, drop_count unchanged.
REQ-033 clear_start with color 8'h00, width=4, height=3 -> 12 writes, addrs 0..11, data 0, pixel_ready=0 throughout, then IDLE.
REQ-034 frame_end rising the same cycle as the last pixel -> that pixel written, frame_done pulses 1 cycle after the write, exactly once.
REQ-035 reset low during CLEAR at addr 5 -> fb_wr_en=0 immediately, no further writes, all counters 0 after release.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types for the pixel framebuffer writer.
// State encoding, stream widths and the frame bounds test.
package gpu_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FLUSH,
    ST_DONE
  } fb_state_e;

  function automatic logic in_frame(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] w,
    input logic [COORD_W-1:0] h
  );
    return (x < w) && (y < h);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// fb_addr_calc: first pipeline stage of the pixel writer.
// Registers the linear address, color and bounds verdict.
module fb_addr_calc
  import gpu_pkg::*;
#(
  parameter int FB_ADDR_W = 16,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 px_valid,
  input  logic                 px_draw,
  input  logic [COORD_W-1:0]   px_x,
  input  logic [COORD_W-1:0]   px_y,
  input  logic [COLOR_W-1:0]   px_color,
  input  logic [COORD_W-1:0]   width,
  input  logic [COORD_W-1:0]   height,
  output logic                 stg_valid,
  output logic                 stg_write,
  output logic                 stg_drop,
  output logic [FB_ADDR_W-1:0] stg_addr,
  output logic [COLOR_W-1:0]   stg_color
);

  logic [2*COORD_W-1:0] prod;
  logic [2*COORD_W:0]   full;
  logic                 inb;

  // full-precision y*width+x, truncated only when registered
  always_comb begin
    prod = {{COORD_W{1'b0}}, px_y}
         * {{COORD_W{1'b0}}, width};
    full = {1'b0, prod}
         + {{(COORD_W+1){1'b0}}, px_x};
    inb = in_frame(px_x, px_y, width, height);
  end

  // stage register; draw=0 pixels pass as empty bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_valid <= 1'b0;
      stg_write <= 1'b0;
      stg_drop  <= 1'b0;
      stg_addr  <= '0;
      stg_color <= '0;
    end else begin
      stg_valid <= px_valid;
      stg_write <= px_valid & px_draw & inb;
      stg_drop  <= px_valid & px_draw & ~inb;
      stg_addr  <= FB_ADDR_W'(full);
      stg_color <= px_color;
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: rasterizer pixel stream to framebuffer,
// with frame clear fill and end-of-frame flush.
module pixel_fb_writer
  import gpu_pkg::*;
#(
  parameter int FB_ADDR_W = 16,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLOR_W-1:0]   pixel_color,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic                 pixel_valid,
  output logic                 pixel_ready,
  input  logic                 draw,
  input  logic [COORD_W-1:0]   width,
  input  logic [COORD_W-1:0]   height,
  input  logic                 frame_end,
  input  logic                 clear_start,
  input  logic [COLOR_W-1:0]   clear_color,
  output logic                 fb_wr_en,
  output logic [FB_ADDR_W-1:0] fb_wr_addr,
  output logic [COLOR_W-1:0]   fb_wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic [31:0]          pixel_count,
  output logic [15:0]          drop_count
);

  fb_state_e state_q;
  fb_state_e state_d;

  logic                 xfer;
  logic                 fe_q;
  logic                 fe_rise;
  logic                 drained;
  logic                 s2_valid;
  logic                 clr_we;
  logic                 clr_enter;
  logic                 clr_last;
  logic [2*COORD_W-1:0] clr_idx;
  logic [2*COORD_W-1:0] clr_limit;
  logic [COLOR_W-1:0]   clr_color;

  logic                 stg_valid;
  logic                 stg_write;
  logic                 stg_drop;
  logic [FB_ADDR_W-1:0] stg_addr;
  logic [COLOR_W-1:0]   stg_color;

  fb_addr_calc #(
    .FB_ADDR_W(FB_ADDR_W),
    .COLOR_W  (COLOR_W)
  ) u_calc (
    .clk      (clk),
    .reset    (reset),
    .px_valid (xfer),
    .px_draw  (draw),
    .px_x     (pixel_x),
    .px_y     (pixel_y),
    .px_color (pixel_color),
    .width    (width),
    .height   (height),
    .stg_valid(stg_valid),
    .stg_write(stg_write),
    .stg_drop (stg_drop),
    .stg_addr (stg_addr),
    .stg_color(stg_color)
  );

  // stage 2 retires during the cycle it is loaded, so an
  // empty stage 1 means the pipe is empty from the next edge
  assign xfer    = pixel_valid & pixel_ready;
  assign fe_rise = frame_end & ~fe_q;
  assign drained = ~stg_valid;
  assign clr_last = ({1'b0, clr_idx} + 23'd1)
                 >= {1'b0, clr_limit};
  assign busy = (state_q != ST_IDLE)
              | stg_valid | s2_valid;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          if (drained) state_d = ST_CLEAR;
        end else if (fe_rise) begin
          state_d = ST_FLUSH;
        end
      end
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      ST_FLUSH: if (drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    pixel_ready = 1'b0;
    clr_we      = 1'b0;
    clr_enter   = 1'b0;
    frame_done  = 1'b0;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        pixel_ready = ~clear_start;
        clr_enter   = clear_start & drained;
      end
      state_q == ST_CLEAR: clr_we = clr_idx < clr_limit;
      state_q == ST_DONE:  frame_done = 1'b1;
      default: ;
    endcase
  end

  // frame_end edge detector, idle-high after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fe_q <= 1'b1;
    else        fe_q <= frame_end;
  end

  // clear fill parameters and sweep index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_idx   <= '0;
      clr_limit <= '0;
      clr_color <= '0;
    end else if (clr_enter) begin
      clr_idx   <= '0;
      clr_limit <= {{COORD_W{1'b0}}, width}
                 * {{COORD_W{1'b0}}, height};
      clr_color <= clear_color;
    end else if (clr_we) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // stage 2: framebuffer write port, clear or pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid   <= 1'b0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else begin
      s2_valid <= stg_valid;
      fb_wr_en <= clr_we | stg_write;
      if (clr_we) begin
        fb_wr_addr <= FB_ADDR_W'(clr_idx);
        fb_wr_data <= clr_color;
      end else if (stg_write) begin
        fb_wr_addr <= stg_addr;
        fb_wr_data <= stg_color;
      end
    end
  end

  // write and drop statistics, zeroed by a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
      drop_count  <= '0;
    end else if (clr_enter) begin
      pixel_count <= '0;
      drop_count  <= '0;
    end else begin
      if (stg_write)
        pixel_count <= pixel_count + 1'b1;
      if (stg_drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// tb_pixel_fb_writer: directed checks of the pixel writer.
// Inputs change on negedge, outputs are read on negedge.
module tb_pixel_fb_writer;

  localparam int AW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] pixel_color = '0;
  logic [10:0]   pixel_x = '0;
  logic [10:0]   pixel_y = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic          draw = 1'b0;
  logic [10:0]   width = 11'd4;
  logic [10:0]   height = 11'd3;
  logic          frame_end = 1'b0;
  logic          clear_start = 1'b0;
  logic [CW-1:0] clear_color = '0;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [CW-1:0] fb_wr_data;
  logic          busy;
  logic          frame_done;
  logic [31:0]   pixel_count;
  logic [15:0]   drop_count;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [AW-1:0] wa_q[$];
  logic [CW-1:0] wd_q[$];
  int            wc_q[$];
  int            fd_q[$];

  pixel_fb_writer #(.FB_ADDR_W(AW), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset),
    .pixel_color(pixel_color), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .draw(draw),
    .width(width), .height(height),
    .frame_end(frame_end), .clear_start(clear_start),
    .clear_color(clear_color), .fb_wr_en(fb_wr_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .busy(busy), .frame_done(frame_done),
    .pixel_count(pixel_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_wr_en) begin
      wa_q.push_back(fb_wr_addr);
      wd_q.push_back(fb_wr_data);
      wc_q.push_back(cyc);
    end
    if (frame_done) fd_q.push_back(cyc);
  end

  task automatic flush_q();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    fd_q.delete();
  endtask

  task automatic set_px(input int x, input int y,
                        input logic [7:0] c, input logic d);
    pixel_valid = 1'b1;
    pixel_x = 11'(x);
    pixel_y = 11'(y);
    pixel_color = c;
    draw = d;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !fb_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_wr: got en=%0b a=%0h d=%0h want 0",
               fb_wr_en, fb_wr_addr, fb_wr_data);
    end
    n_checks++;
    if ({busy, frame_done, pixel_count, drop_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_stat: busy=%0b fd=%0b pc=%0d dc=%0d want 0",
               busy, frame_done, pixel_count, drop_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b want 1", pixel_ready);
    end
  endtask

  task automatic test_single();
    width = 11'd4;
    height = 11'd3;
    flush_q();
    set_px(2, 1, 8'h5A, 1'b1);
    @(negedge clk);
    pixel_valid = 1'b0;
    draw = 1'b0;
    n_checks++;
    if (fb_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: got en=%0b want 0", fb_wr_en);
    end
    @(negedge clk);
    n_checks++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data, pixel_count}
        !== {1'b1, 16'd6, 8'h5A, 32'd1}) begin
      n_fail++;
      $display("FAIL single_wr: got en=%0b a=%0d d=%0h pc=%0d want 1 6 5a 1",
               fb_wr_en, fb_wr_addr, fb_wr_data, pixel_count);
    end
    @(negedge clk);
    n_checks++;
    if ({fb_wr_en, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_after: got en=%0b busy=%0b want 0 0",
               fb_wr_en, busy);
    end
  endtask

  task automatic test_back_to_back();
    int not_rdy;
    int bad;
    bit ok;
    not_rdy = 0;
    bad = 0;
    flush_q();
    for (int i = 0; i < 12; i++) begin
      if (pixel_ready !== 1'b1) not_rdy++;
      set_px(i % 4, i / 4, 8'(8'h10 + i), 1'b1);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok || not_rdy != 0) begin
      n_fail++;
      $display("FAIL b2b_flow: got idle=%0b notready=%0d want 1 0",
               ok, not_rdy);
    end
    n_checks++;
    if (wa_q.size() != 12) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes want 12", wa_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (wa_q[i] != AW'(i)) bad++;
        if (wd_q[i] != 8'(8'h10 + i)) bad++;
        if (i > 0 && wc_q[i] != wc_q[i-1] + 1) bad++;
      end
    end
    n_checks++;
    if (bad != 0 || pixel_count !== 32'd13) begin
      n_fail++;
      $display("FAIL b2b_data: got bad=%0d pc=%0d want 0 13",
               bad, pixel_count);
    end
  endtask

  task automatic test_drop();
    bit ok;
    flush_q();
    set_px(4, 0, 8'hE1, 1'b1);
    @(negedge clk);
    set_px(0, 3, 8'hE2, 1'b1);
    @(negedge clk);
    pixel_valid = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok || wa_q.size() != 0 || drop_count !== 16'd2) begin
      n_fail++;
      $display("FAIL drop_oob: got idle=%0b wr=%0d dc=%0d want 1 0 2",
               ok, wa_q.size(), drop_count);
    end
    set_px(1, 1, 8'hE3, 1'b0);
    @(negedge clk);
    pixel_valid = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok || wa_q.size() != 0 || drop_count !== 16'd2
        || pixel_count !== 32'd13) begin
      n_fail++;
      $display("FAIL drop_nodraw: got wr=%0d dc=%0d pc=%0d want 0 2 13",
               wa_q.size(), drop_count, pixel_count);
    end
  endtask

  task automatic test_frame_end();
    int wcyc;
    int fcyc;
    logic [AW-1:0] a;
    logic [CW-1:0] d;
    flush_q();
    set_px(3, 2, 8'hC3, 1'b1);
    frame_end = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    repeat (20) @(negedge clk);
    a = (wa_q.size() > 0) ? wa_q[0] : 'x;
    d = (wd_q.size() > 0) ? wd_q[0] : 'x;
    wcyc = (wc_q.size() > 0) ? wc_q[0] : -100;
    fcyc = (fd_q.size() > 0) ? fd_q[0] : -200;
    n_checks++;
    if (wa_q.size() != 1 || a !== 16'd11 || d !== 8'hC3) begin
      n_fail++;
      $display("FAIL fe_write: got n=%0d a=%0d d=%0h want 1 11 c3",
               wa_q.size(), a, d);
    end
    n_checks++;
    if (fd_q.size() != 1 || fcyc != wcyc + 1) begin
      n_fail++;
      $display("FAIL fe_done: got pulses=%0d at %0d want 1 at %0d",
               fd_q.size(), fcyc, wcyc + 1);
    end
    n_checks++;
    if (pixel_count !== 32'd14) begin
      n_fail++;
      $display("FAIL fe_count: got %0d want 14", pixel_count);
    end
    frame_end = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [AW-1:0] a;
    flush_q();
    width = 11'd300;
    height = 11'd300;
    set_px(299, 299, 8'h77, 1'b1);
    @(negedge clk);
    set_px(300, 0, 8'h78, 1'b1);
    @(negedge clk);
    pixel_valid = 1'b0;
    wait_idle(ok);
    a = (wa_q.size() > 0) ? wa_q[0] : 'x;
    n_checks++;
    if (wa_q.size() != 1 || a !== 16'd24463) begin
      n_fail++;
      $display("FAIL wrap_addr: got n=%0d a=%0d want 1 24463",
               wa_q.size(), a);
    end
    n_checks++;
    if (drop_count !== 16'd3 || pixel_count !== 32'd15) begin
      n_fail++;
      $display("FAIL wrap_count: got dc=%0d pc=%0d want 3 15",
               drop_count, pixel_count);
    end
    width = 11'd4;
    height = 11'd3;
  endtask

  task automatic test_clear();
    int rdy_bad;
    int bad;
    bit ok;
    rdy_bad = 0;
    bad = 0;
    ok = 1'b0;
    flush_q();
    clear_start = 1'b1;
    clear_color = 8'h00;
    set_px(3, 2, 8'hFF, 1'b1);
    #1;
    n_checks++;
    if (pixel_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_req_ready: got %0b want 0", pixel_ready);
    end
    @(negedge clk);
    clear_start = 1'b0;
    pixel_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && pixel_ready) rdy_bad++;
      if (!busy && !fb_wr_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok || rdy_bad != 0 || wa_q.size() != 12) begin
      n_fail++;
      $display("FAIL clr_flow: got idle=%0b rdy=%0d n=%0d want 1 0 12",
               ok, rdy_bad, wa_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (wa_q[i] != AW'(i) || wd_q[i] != 8'h00) bad++;
        if (i > 0 && wc_q[i] != wc_q[i-1] + 1) bad++;
      end
    end
    n_checks++;
    if (bad != 0 || pixel_count !== 0 || drop_count !== 0
        || pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_data: got bad=%0d pc=%0d dc=%0d rdy=%0b want 0 0 0 1",
               bad, pixel_count, drop_count, pixel_ready);
    end
  endtask

  task automatic test_clear_zero();
    flush_q();
    width = 11'd0;
    clear_start = 1'b1;
    clear_color = 8'h33;
    @(negedge clk);
    clear_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr0_enter: got busy=%0b want 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr0_exit: got busy=%0b rdy=%0b want 0 1",
               busy, pixel_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL clr0_writes: got %0d want 0", wa_q.size());
    end
    width = 11'd4;
  endtask

  task automatic test_reset_mid_clear();
    bit hit;
    hit = 1'b0;
    clear_start = 1'b1;
    clear_color = 8'hAA;
    @(negedge clk);
    clear_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (fb_wr_en && fb_wr_addr == 16'd5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_reach: got no write at addr 5 want one");
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({fb_wr_en, fb_wr_addr, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_now: got en=%0b a=%0d busy=%0b want 0 0 0",
               fb_wr_en, fb_wr_addr, busy);
    end
    flush_q();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (wa_q.size() != 0 || pixel_count !== 0 || drop_count !== 0
        || pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_after: got n=%0d pc=%0d dc=%0d rdy=%0b want 0 0 0 1",
               wa_q.size(), pixel_count, drop_count, pixel_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_frame_end();
    test_wrap();
    test_clear();
    test_clear_zero();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
